alu_bcd_serial: RTL and testbench

//  Multi-cycle 65C816 ADC/SBC datapath: processes 8/16-bit operands one nibble per clock in binary or decimal mode.

---
 rtl/alu_bcd_pkg.sv | 21 ++
 rtl/alu_nibble_slice.sv | 51 +++++
 rtl/alu_bcd_serial.sv | 163 ++++++++++++++++
 tb/tb_alu_bcd_serial.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : alu_bcd_pkg                                                      |
// | Shared FSM state type and nibble/BCD constants for alu_bcd_serial.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] NIB_LAST_8  = 2'd1;
  localparam logic [1:0] NIB_LAST_16 = 2'd3;
  localparam logic [3:0] BCD_ADJ_ADD = 4'd6;
  localparam logic [3:0] BCD_ADJ_SUB = 4'd10;

endpackage
`default_nettype wire

// File: rtl/alu_nibble_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_nibble_slice                                                 |
// | Combinational 4-bit binary/BCD add-subtract slice with carry and overflow. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_nibble_slice
  import alu_bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       add,
  input  logic       bcd,
  output logic [3:0] s,
  output logic       co,
  output logic       vo
);

  logic [3:0] b_eff;
  logic [4:0] bin;

  assign b_eff = b ^ {4{~add}};
  assign bin   = {1'b0, a} + {1'b0, b_eff} + {4'd0, cin};
  // Overflow is taken from the raw binary sum, before any decimal correction.
  assign vo    = ~(a[3] ^ b_eff[3]) & (a[3] ^ bin[3]);

  always_comb begin
    s  = bin[3:0];
    co = bin[4];
    if (bcd) begin
      if (add) begin
        if (bin > 5'd9) begin
          s  = bin[3:0] + BCD_ADJ_ADD;
          co = 1'b1;
        end else begin
          co = 1'b0;
        end
      end else begin
        if (!bin[4]) begin
          s  = bin[3:0] + BCD_ADJ_SUB;
          co = 1'b0;
        end else begin
          co = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_bcd_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_bcd_serial                                                   |
// | Nibble-serial 65C816 ADC/SBC datapath, 8/16-bit, binary or decimal.        |
// | Option  : ALU_BCD_CHECK_EN enables invalid-BCD-digit reporting on ERR.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_bcd_serial
  import alu_bcd_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CI,
  input  logic        ADD,
  input  logic        BCD,
  input  logic        W16,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] RESULT,
  output logic        N_O,
  output logic        V_O,
  output logic        Z_O,
  output logic        C_O,
  output logic        ERR
);

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic        add_q, add_d, bcd_q, bcd_d, w16_q, w16_d;
  logic        carry_q, carry_d, v_q, v_d, n_q, n_d, z_q, z_d;
  logic [1:0]  idx_q, idx_d;

  logic [3:0]  a_nib, b_nib, slice_s;
  logic        slice_co, slice_vo;
  logic [1:0]  nib_last;

  assign a_nib    = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib    = b_q[{idx_q, 2'b00} +: 4];
  assign nib_last = w16_q ? NIB_LAST_16 : NIB_LAST_8;

  alu_nibble_slice u_slice (
    .a   (a_nib),
    .b   (b_nib),
    .cin (carry_q),
    .add (add_q),
    .bcd (bcd_q),
    .s   (slice_s),
    .co  (slice_co),
    .vo  (slice_vo)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    add_d    = add_q;
    bcd_d    = bcd_q;
    w16_d    = w16_q;
    carry_d  = carry_q;
    v_d      = v_q;
    n_d      = n_q;
    z_d      = z_q;
    idx_d    = idx_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          a_d      = A;
          b_d      = B;
          add_d    = ADD;
          bcd_d    = BCD;
          w16_d    = W16;
          carry_d  = CI;
          idx_d    = 2'd0;
          // High byte starts as A so 8-bit ops leave the B accumulator intact.
          result_d = {A[15:8], 8'h00};
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[{idx_q, 2'b00} +: 4] = slice_s;
        carry_d = slice_co;
        v_d     = slice_vo;
        idx_d   = idx_q + 2'd1;
        if (idx_q == nib_last) begin
          z_d     = w16_q ? (result_d == 16'h0000) : (result_d[7:0] == 8'h00);
          n_d     = w16_q ? result_d[15] : result_d[7];
          state_d = DONE;
        end
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      add_q    <= 1'b0;
      bcd_q    <= 1'b0;
      w16_q    <= 1'b0;
      carry_q  <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      idx_q    <= 2'd0;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      add_q    <= add_d;
      bcd_q    <= bcd_d;
      w16_q    <= w16_d;
      carry_q  <= carry_d;
      v_q      <= v_d;
      n_q      <= n_d;
      z_q      <= z_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign RESULT    = result_q;
  assign N_O       = n_q;
  assign V_O       = v_q;
  assign Z_O       = z_q;
  assign C_O       = carry_q;

`ifdef ALU_BCD_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && IN_VALID) begin
      err_d = 1'b0;
    end else if (state_q == RUN && bcd_q && (a_nib > 4'd9 || b_nib > 4'd9)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign ERR = err_q & (state_q == DONE);
`else
  assign ERR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_bcd_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_alu_bcd_serial                                                |
// | Directed self-checking bench for alu_bcd_serial (ALU_BCD_CHECK_EN aware).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_bcd_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        ci = 1'b0;
  logic        add = 1'b1;
  logic        bcd = 1'b0;
  logic        w16 = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        n_o, v_o, z_o, c_o, err;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [15:0] held_res;
  logic [3:0]  held_flags;

  always #5 clk = ~clk;

  alu_bcd_serial dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .A         (a),
    .B         (b),
    .CI        (ci),
    .ADD       (add),
    .BCD       (bcd),
    .W16       (w16),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .RESULT    (result),
    .N_O       (n_o),
    .V_O       (v_o),
    .Z_O       (z_o),
    .C_O       (c_o),
    .ERR       (err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request, returns cycles from the accepting edge to OUT_VALID.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tci,
                          input logic tadd, input logic tbcd, input logic tw16,
                          output int latency);
    a = ta; b = tb_; ci = tci; add = tadd; bcd = tbcd; w16 = tw16;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    latency = 0;
    while (!out_valid && latency < 20) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  task automatic release_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, {15'd0, in_ready}, 16'h0001);
    check({tag, "_idle_valid"}, {15'd0, out_valid}, 16'h0000);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {15'd0, in_ready}, 16'h0001);
    check("rst_out_valid", {15'd0, out_valid}, 16'h0000);
    check("rst_result", result, 16'h0000);
    check("rst_flags", {12'd0, n_o, v_o, z_o, c_o}, 16'h0000);
    check("rst_err", {15'd0, err}, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    // 8-bit BCD ADC 45+38, then hold the result under backpressure
    start_op(16'h0045, 16'h0038, 1'b0, 1'b1, 1'b1, 1'b0, lat);
    check("bcd_add8_lat", lat[15:0], 16'd2);
    check("bcd_add8_res", result, 16'h0083);
    check("bcd_add8_nvzc", {12'd0, n_o, v_o, z_o, c_o}, 16'h000C);
    held_res   = result;
    held_flags = {n_o, v_o, z_o, c_o};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_result", result, held_res);
      check("bp_flags", {12'd0, n_o, v_o, z_o, c_o}, {12'd0, held_flags});
      check("bp_in_ready", {15'd0, in_ready}, 16'h0000);
      check("bp_out_valid", {15'd0, out_valid}, 16'h0001);
    end
    release_op("bcd_add8");

    // 8-bit BCD ADC 99+01 wraps to zero, high byte preserved
    start_op(16'h1299, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, lat);
    check("bcd_wrap_res", result, 16'h1200);
    check("bcd_wrap_nvzc", {12'd0, n_o, v_o, z_o, c_o}, 16'h0003);
    release_op("bcd_wrap");

    // 16-bit BCD SBC 1000-0001
    start_op(16'h1000, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1, lat);
    check("bcd_sub16_lat", lat[15:0], 16'd4);
    check("bcd_sub16_res", result, 16'h0999);
    check("bcd_sub16_nvzc", {12'd0, n_o, v_o, z_o, c_o}, 16'h0001);
    release_op("bcd_sub16");

    // 8-bit binary ADC 7F+01 signed overflow
    start_op(16'h007F, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, lat);
    check("bin_ovf_res", result, 16'h0080);
    check("bin_ovf_nvzc", {12'd0, n_o, v_o, z_o, c_o}, 16'h000C);
    release_op("bin_ovf");

    // 8-bit binary SBC AB50-0010, high byte from A
    start_op(16'hAB50, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    check("bin_sub8_res", result, 16'hAB40);
    check("bin_sub8_nvzc", {12'd0, n_o, v_o, z_o, c_o}, 16'h0001);
    release_op("bin_sub8");

    // 16-bit binary ADC FFFF+0001 full carry out
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, lat);
    check("bin_add16_lat", lat[15:0], 16'd4);
    check("bin_add16_res", result, 16'h0000);
    check("bin_add16_nvzc", {12'd0, n_o, v_o, z_o, c_o}, 16'h0003);
    release_op("bin_add16");

    // Invalid BCD digit, then the same operands in binary mode
    start_op(16'h000A, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, lat);
    check("bad_bcd_res", result, 16'h0010);
`ifdef ALU_BCD_CHECK_EN
    check("bad_bcd_err", {15'd0, err}, 16'h0001);
`else
    check("bad_bcd_err", {15'd0, err}, 16'h0000);
`endif
    release_op("bad_bcd");
    check("err_cleared", {15'd0, err}, 16'h0000);
    start_op(16'h000A, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, lat);
    check("bin_a_res", result, 16'h000A);
    check("bin_a_err", {15'd0, err}, 16'h0000);
    release_op("bin_a");

    // Reset in the middle of a 16-bit operation
    a = 16'h1234; b = 16'h1111; ci = 1'b0; add = 1'b1; bcd = 1'b0; w16 = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_run_busy", {15'd0, in_ready}, 16'h0000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", {15'd0, in_ready}, 16'h0001);
    check("mid_rst_out_valid", {15'd0, out_valid}, 16'h0000);
    check("mid_rst_result", result, 16'h0000);
    check("mid_rst_flags", {12'd0, n_o, v_o, z_o, c_o}, 16'h0000);
    check("mid_rst_err", {15'd0, err}, 16'h0000);
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_stays_idle", {15'd0, out_valid}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
